// File: rtl/dmac_master.sv
// Single-channel DMA engine: register-programmed word copy from source to destination
// memory as bus master M1, holding the bus for the whole burst and interrupting on completion.
module dmac_master #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              S_sel,
  input  logic              S_wr,
  input  logic [3:0]        S_address,
  input  logic [DATA_W-1:0] S_din,
  output logic [DATA_W-1:0] S_dout,
  output logic              M_req,
  input  logic              M_grant,
  output logic [ADDR_W-1:0] M_address,
  output logic              M_wr,
  output logic [DATA_W-1:0] M_dout,
  input  logic [DATA_W-1:0] M_din,
  output logic              interrupt
);

  typedef enum logic [2:0] {IDLE, REQ, READ, LATCH, WRITE, DONE} state_e;

  state_e              state_q, state_d;
  logic                intFlag_q, intFlag_d;
  logic                intEn_q, intEn_d;
  logic [ADDR_W-1:0]   srcAddr_q, srcAddr_d;
  logic [ADDR_W-1:0]   dstAddr_q, dstAddr_d;
  logic [ADDR_W-1:0]   dataSize_q, dataSize_d;
  logic [ADDR_W-1:0]   srcPtr_q, srcPtr_d;
  logic [ADDR_W-1:0]   dstPtr_q, dstPtr_d;
  logic [ADDR_W-1:0]   remaining_q, remaining_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic busy;
  logic regWrite;
  logic startReq;
  logic unusedBits;

  assign busy       = (state_q != IDLE);
  assign regWrite   = S_sel & S_wr;
  assign startReq   = regWrite && (S_address == 4'h0) && S_din[0] && !busy;
  assign interrupt  = intFlag_q & intEn_q;
  assign unusedBits = ^S_din[DATA_W-1:ADDR_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      intFlag_q   <= 1'b0;
      intEn_q     <= 1'b0;
      srcAddr_q   <= '0;
      dstAddr_q   <= '0;
      dataSize_q  <= '0;
      srcPtr_q    <= '0;
      dstPtr_q    <= '0;
      remaining_q <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      intFlag_q   <= intFlag_d;
      intEn_q     <= intEn_d;
      srcAddr_q   <= srcAddr_d;
      dstAddr_q   <= dstAddr_d;
      dataSize_q  <= dataSize_d;
      srcPtr_q    <= srcPtr_d;
      dstPtr_q    <= dstPtr_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
    end
  end

  // Register writes come first so a completion set later in this block wins over a same-cycle clear.
  always_comb begin
    state_d     = state_q;
    intFlag_d   = intFlag_q;
    intEn_d     = intEn_q;
    srcAddr_d   = srcAddr_q;
    dstAddr_d   = dstAddr_q;
    dataSize_d  = dataSize_q;
    srcPtr_d    = srcPtr_q;
    dstPtr_d    = dstPtr_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    M_req       = 1'b0;
    M_address   = '0;
    M_wr        = 1'b0;
    M_dout      = '0;

    if (regWrite) begin
      case (S_address)
        4'h1: if (!S_din[0]) intFlag_d = 1'b0;
        4'h2: intEn_d = S_din[0];
        4'h3: if (!busy) srcAddr_d = S_din[ADDR_W-1:0];
        4'h4: if (!busy) dstAddr_d = S_din[ADDR_W-1:0];
        4'h5: if (!busy) dataSize_d = S_din[ADDR_W-1:0];
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (startReq) begin
          if (dataSize_q != '0) begin
            state_d     = REQ;
            srcPtr_d    = srcAddr_q;
            dstPtr_d    = dstAddr_q;
            remaining_d = dataSize_q;
          end else begin
            intFlag_d = 1'b1;
          end
        end
      end
      REQ: begin
        M_req = 1'b1;
        if (M_grant) state_d = READ;
      end
      READ: begin
        M_req     = 1'b1;
        M_address = srcPtr_q;
        if (M_grant) state_d = LATCH;
      end
      // Capture only on a granted cycle, so a stalled LATCH takes M_din again once the bus returns.
      LATCH: begin
        M_req = 1'b1;
        if (M_grant) begin
          data_d   = M_din;
          srcPtr_d = srcPtr_q + ADDR_W'(1);
          state_d  = WRITE;
        end
      end
      WRITE: begin
        M_req     = 1'b1;
        M_address = dstPtr_q;
        M_dout    = data_q;
        if (M_grant) begin
          M_wr        = 1'b1;
          dstPtr_d    = dstPtr_q + ADDR_W'(1);
          remaining_d = remaining_q - ADDR_W'(1);
          state_d     = (remaining_q == ADDR_W'(1)) ? DONE : READ;
        end
      end
      DONE: begin
        intFlag_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    S_dout = '0;
    if (S_sel && !S_wr) begin
      case (S_address)
        4'h1: S_dout[0] = intFlag_q;
        4'h2: S_dout[0] = intEn_q;
        4'h3: S_dout[ADDR_W-1:0] = srcAddr_q;
        4'h4: S_dout[ADDR_W-1:0] = dstAddr_q;
        4'h5: S_dout[ADDR_W-1:0] = dataSize_q;
        4'h6: S_dout[0] = busy;
        default: S_dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmac_master.sv
// Self-checking bench for dmac_master: directed scenarios plus randomized copies with random grant
// loss, all compared against a word-level copy model and a bus memory kept in the bench.
module tb_dmac_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        S_sel = 1'b0;
  logic        S_wr = 1'b0;
  logic [3:0]  S_address = 4'h0;
  logic [31:0] S_din = '0;
  logic [31:0] S_dout;
  logic        M_req;
  logic        M_grant;
  logic [7:0]  M_address;
  logic        M_wr;
  logic [31:0] M_dout;
  logic [31:0] M_din;
  logic        interrupt;

  logic        grantEn = 1'b1;
  bit          dropMode = 1'b0;
  logic [31:0] mem [256];
  logic [31:0] refMem [256];
  logic [31:0] rdata = '0;
  int          cycleCnt = 0;
  int          total = 0;
  int          bad = 0;
  int          reqRises = 0;
  int          badWr = 0;
  logic        prevReq = 1'b0;
  logic [7:0]  wrAddrQ [$];
  int          wrCycQ [$];

  always #5 clk = ~clk;

  dmac_master dut (
    .clk(clk), .reset_n(reset_n),
    .S_sel(S_sel), .S_wr(S_wr), .S_address(S_address), .S_din(S_din), .S_dout(S_dout),
    .M_req(M_req), .M_grant(M_grant), .M_address(M_address), .M_wr(M_wr),
    .M_dout(M_dout), .M_din(M_din), .interrupt(interrupt)
  );

  // The arbiter grants M1 whenever it asks and the bench is not holding the bus for M0.
  assign M_grant = M_req & grantEn;
  assign M_din   = rdata;

  always @(posedge clk) begin
    cycleCnt++;
    if (M_req && M_grant) begin
      if (M_wr) mem[M_address] = M_dout;
      else rdata <= mem[M_address];
    end
  end

  always @(negedge clk) begin
    if (M_wr) begin
      wrAddrQ.push_back(M_address);
      wrCycQ.push_back(cycleCnt);
      if (!M_grant) badWr++;
    end
    if (M_req && !prevReq) reqRises++;
    prevReq = M_req;
  end

  always @(negedge clk) begin
    #2;
    if (dropMode) grantEn = ($urandom_range(0, 3) != 0);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic regWrite(input logic [3:0] a, input logic [31:0] d);
    S_sel = 1'b1; S_wr = 1'b1; S_address = a; S_din = d;
    @(negedge clk);
    S_sel = 1'b0; S_wr = 1'b0; S_din = '0;
  endtask

  task automatic regRead(input logic [3:0] a, output logic [31:0] d);
    S_sel = 1'b1; S_wr = 1'b0; S_address = a;
    #1 d = S_dout;
    S_sel = 1'b0;
  endtask

  task automatic waitIrq(output int cyc, input int budget);
    cyc = 0;
    while (!interrupt && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (!interrupt) checkOutput("irq_timeout", 32'd0, 32'd1);
  endtask

  // Expected destination contents: an in-order word copy applied to a snapshot of memory.
  task automatic buildRef(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] size);
    for (int i = 0; i < 256; i++) refMem[i] = mem[i];
    for (int i = 0; i < int'(size); i++) refMem[8'(dst + i)] = refMem[8'(src + i)];
    wrAddrQ.delete();
    wrCycQ.delete();
    reqRises = 0;
  endtask

  task automatic checkMem(input string tag);
    int mism = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== refMem[i]) mism++;
    checkOutput(tag, mism, 0);
  endtask

  task automatic applyStimulus(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] size,
                               input bit drops, input bit timed);
    int cyc;
    regWrite(4'h3, {24'h0, src});
    regWrite(4'h4, {24'h0, dst});
    regWrite(4'h5, {24'h0, size});
    regWrite(4'h2, 32'h1);
    buildRef(src, dst, size);
    dropMode = drops;
    regWrite(4'h0, 32'h1);
    if (timed) checkOutput("req_after_start", M_req, size != 0);
    waitIrq(cyc, 40 * int'(size) + 100);
    dropMode = 1'b0;
    grantEn = 1'b1;
    if (timed) checkOutput("latency", cyc, (size == 0) ? 0 : 3 * int'(size) + 2);
    checkOutput("irq", interrupt, 1);
    checkOutput("req_released", M_req, 0);
    checkOutput("wr_count", wrAddrQ.size(), size);
    for (int i = 0; i < wrAddrQ.size(); i++) checkOutput("wr_addr", wrAddrQ[i], 8'(dst + i));
    if (timed)
      for (int i = 1; i < wrCycQ.size(); i++) checkOutput("wr_spacing", wrCycQ[i] - wrCycQ[i-1], 3);
    checkOutput("req_rises", reqRises, size != 0);
    checkMem("mem_copy");
    regWrite(4'h1, 32'h0);
    checkOutput("irq_clear", interrupt, 0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] acc;
    logic [31:0] expWord;
    int          cyc;
    int          n;

    for (int i = 0; i < 256; i++) mem[i] = $urandom;

    repeat (2) @(negedge clk);
    checkOutput("rst_req", M_req, 0);
    checkOutput("rst_wr", M_wr, 0);
    checkOutput("rst_addr", M_address, 0);
    checkOutput("rst_dout", M_dout, 0);
    checkOutput("rst_irq", interrupt, 0);
    acc = '0;
    for (int a = 0; a < 16; a++) begin
      regRead(4'(a), rd);
      acc = acc | rd;
    end
    checkOutput("rst_regs", acc, 0);
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] register access");
    regWrite(4'h3, 32'h10);
    regWrite(4'h4, 32'h40);
    regWrite(4'h5, 32'h3);
    regWrite(4'h2, 32'h1);
    regRead(4'h3, rd); checkOutput("rd_src", rd, 32'h10);
    regRead(4'h4, rd); checkOutput("rd_dst", rd, 32'h40);
    regRead(4'h5, rd); checkOutput("rd_size", rd, 32'h3);
    regRead(4'h2, rd); checkOutput("rd_inten", rd, 32'h1);
    regRead(4'h6, rd); checkOutput("rd_status", rd, 32'h0);
    regRead(4'hA, rd); checkOutput("rd_unused", rd, 32'h0);
    regRead(4'h0, rd); checkOutput("rd_start", rd, 32'h0);

    $display("[TB] basic copy");
    mem[8'h10] = 32'hAAAA_0001;
    mem[8'h11] = 32'hBBBB_0002;
    mem[8'h12] = 32'hCCCC_0003;
    applyStimulus(8'h10, 8'h40, 8'd3, 1'b0, 1'b1);
    checkOutput("copy_a", mem[8'h40], 32'hAAAA_0001);
    checkOutput("copy_b", mem[8'h41], 32'hBBBB_0002);
    checkOutput("copy_c", mem[8'h42], 32'hCCCC_0003);
    regRead(4'h5, rd); checkOutput("size_kept", rd, 32'h3);

    $display("[TB] boundaries");
    applyStimulus(8'hFE, 8'h80, 8'd3, 1'b0, 1'b1);
    applyStimulus(8'h20, 8'h50, 8'd0, 1'b0, 1'b1);

    $display("[TB] arbitration and start while busy");
    regWrite(4'h3, 32'h20);
    regWrite(4'h4, 32'h60);
    regWrite(4'h5, 32'h4);
    regWrite(4'h2, 32'h1);
    buildRef(8'h20, 8'h60, 8'd4);
    grantEn = 1'b0;
    regWrite(4'h0, 32'h1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("hold_req", M_req, 1);
      checkOutput("hold_wr", M_wr, 0);
      checkOutput("hold_addr", M_address, 0);
      @(negedge clk);
    end
    regRead(4'h6, rd); checkOutput("hold_busy", rd, 32'h1);
    regWrite(4'h5, 32'h9);
    regWrite(4'h3, 32'h33);
    regWrite(4'h0, 32'h1);
    regRead(4'h5, rd); checkOutput("busy_size_locked", rd, 32'h4);
    regRead(4'h3, rd); checkOutput("busy_src_locked", rd, 32'h20);
    grantEn = 1'b1;
    @(negedge clk); checkOutput("grant_wr0", M_wr, 0);
    @(negedge clk); checkOutput("grant_wr1", M_wr, 0);
    @(negedge clk); checkOutput("grant_wr2", M_wr, 1);
    waitIrq(cyc, 100);
    checkOutput("busy_wr_count", wrAddrQ.size(), 4);
    checkOutput("busy_req_rises", reqRises, 1);
    checkMem("busy_mem");
    regWrite(4'h1, 32'h0);

    $display("[TB] interrupt masking");
    regWrite(4'h2, 32'h0);
    regWrite(4'h3, 32'h05);
    regWrite(4'h4, 32'h90);
    regWrite(4'h5, 32'h1);
    expWord = mem[8'h05];
    regWrite(4'h0, 32'h1);
    n = 0;
    regRead(4'h6, rd);
    while (rd[0] && n < 50) begin
      @(negedge clk);
      regRead(4'h6, rd);
      n++;
    end
    checkOutput("mask_idle", rd, 32'h0);
    regRead(4'h1, rd); checkOutput("mask_flag", rd, 32'h1);
    checkOutput("mask_irq", interrupt, 0);
    checkOutput("mask_mem", mem[8'h90], expWord);
    regWrite(4'h2, 32'h1); checkOutput("unmask_irq", interrupt, 1);
    regWrite(4'h1, 32'h1); checkOutput("flag_w1_noeffect", interrupt, 1);
    regWrite(4'h1, 32'h0); checkOutput("flag_clear", interrupt, 0);

    $display("[TB] reset mid-transfer");
    regWrite(4'h3, 32'h30);
    regWrite(4'h4, 32'h70);
    regWrite(4'h5, 32'h4);
    regWrite(4'h0, 32'h1);
    n = 0;
    cyc = 0;
    while (n < 2 && cyc < 50) begin
      @(negedge clk);
      if (M_wr) n++;
      cyc++;
    end
    checkOutput("second_write_seen", n, 2);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_req", M_req, 0);
    checkOutput("mid_rst_wr", M_wr, 0);
    checkOutput("mid_rst_irq", interrupt, 0);
    regRead(4'h6, rd); checkOutput("mid_rst_status", rd, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    applyStimulus(8'h30, 8'h70, 8'd4, 1'b0, 1'b1);

    $display("[TB] randomized copies");
    for (int t = 0; t < 12; t++) begin
      applyStimulus(8'($urandom), 8'($urandom), 8'($urandom_range(0, 10)),
                    1'($urandom_range(0, 1)), 1'b0);
    end

    checkOutput("wr_without_grant", badWr, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmac_master.md
Name: dmac_master

Overview:
- Single-channel DMA engine. Acts as bus master M1 in front of the two-master bus arbiter, and drives the M1_req/M1_grant pair that the arbiter serves.
- The CPU/testbench (master M0) programs the engine through a slave register port. Once started, the engine requests the bus and copies DATA_SIZE words from source to destination memory.
- When the copy is finished, it releases the bus and raises an interrupt.

Parameters:
ADDR_W, 8, width of memory addresses and of the DATA_SIZE count
DATA_W, 32, width of data words and of the slave register port

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
S_sel  input  1  slave register access select
S_wr  input  1  slave write (1) / read (0)
S_address  input  4  register offset
S_din  input  DATA_W  slave write data
S_dout  output  DATA_W  slave read data (combinational)
M_req  output  1  bus request to arbiter (M1_req)
M_grant  input  1  grant from arbiter (M1_grant)
M_address  output  ADDR_W  bus address
M_wr  output  1  bus write strobe
M_dout  output  DATA_W  bus write data
M_din  input  DATA_W  bus read data, valid the cycle after the address is presented
interrupt  output  1  transfer-complete interrupt

Behaviour:
- Clocking and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: all registers 0, state IDLE, M_req=0, M_wr=0, M_address=0, M_dout=0, interrupt=0.
- Register map (offsets 0x0–0x6):
  - 0x0 START: write with S_din[0]=1 launches a transfer. Write-only; reads 0.
  - 0x1 INT_FLAG: bit0 is set by hardware at completion. A write with S_din[0]=0 clears it; a write of 1 has no effect.
  - 0x2 INT_EN: bit0, read/write.
  - 0x3 SRC_ADDR: [ADDR_W-1:0], read/write.
  - 0x4 DST_ADDR: [ADDR_W-1:0], read/write.
  - 0x5 DATA_SIZE: [ADDR_W-1:0], read/write.
  - 0x6 STATUS: bit0 = busy (state != IDLE). Read-only.
  - Other offsets: reads 0, writes ignored.
- Register access rules:
  - S_dout = selected register, zero-extended, when S_sel=1 and S_wr=0. Otherwise S_dout=0.
  - While busy, writes to START, SRC_ADDR, DST_ADDR and DATA_SIZE are ignored. INT_FLAG and INT_EN remain writable.
- interrupt = INT_FLAG & INT_EN, registered-flag driven, no extra latency.
- Working copies: at START the engine latches SRC_ADDR, DST_ADDR and DATA_SIZE into internal src_ptr, dst_ptr and remaining. The programmed registers stay unchanged.
- State machine:
  - IDLE: on START with DATA_SIZE≠0, go to REQ. On START with DATA_SIZE=0, set INT_FLAG, never assert M_req, and stay in IDLE.
  - REQ: M_req=1. Go to READ when M_grant=1.
  - READ: M_address=src_ptr, M_wr=0. Go to LATCH.
  - LATCH: capture M_din into data register, then src_ptr+1. Go to WRITE.
  - WRITE: M_address=dst_ptr, M_wr=1, M_dout=data register, then dst_ptr+1 and remaining-1. If remaining was 1, go to DONE; otherwise go to READ.
  - DONE: M_req=0, set INT_FLAG. Go to IDLE.
- Per-word timing: 3 cycles per word once granted. The first READ occurs the cycle after M_grant is seen high in REQ.
- M_req stays 1 continuously from REQ through the last WRITE, so the arbiter holds the grant for the whole burst.
- Grant loss: if M_grant=0 in READ, LATCH or WRITE, the engine holds its state and pointers, forces M_wr=0, and keeps M_req=1. It resumes when the grant returns. A LATCH stalled by grant loss re-captures M_din.
- Address and data arithmetic: pointers wrap modulo 2^ADDR_W (0xFF+1 → 0x00). No overlap checking; the copy proceeds in ascending order.
- Idle outputs: outside READ and WRITE, M_address=0, M_wr=0, M_dout=0.
- Reset mid-transfer: everything returns immediately (asynchronously) to reset values, and M_req drops in the same instant.

Test Plan:
- Register access: write SRC=0x10, DST=0x40, SIZE=3, INT_EN=1, then read each back -> values 0x10, 0x40, 0x3, 0x1. STATUS=0. Unused offset 0xA reads 0.
- Basic copy: mem[0x10..0x12]={A,B,C}, START, arbiter grants M1 -> M_req rises one cycle after START. mem[0x40..0x42]={A,B,C}. Exactly 3 M_wr pulses, 3 cycles apart. interrupt=1 after DONE. M_req=0. Writing INT_FLAG=0 drops interrupt.
- Arbitration: M0 holding the bus when START is issued -> engine waits in REQ with M_req=1 and no bus activity. Transfer begins the cycle after M_grant=1. Grant is held until the last WRITE.
- Boundaries:
  - SIZE=0 START -> interrupt within 1 cycle, M_req never asserted.
  - SRC=0xFE, SIZE=3 -> reads 0xFE, 0xFF, 0x00.
  - START while busy -> ignored, and the copy count is unchanged.
- Reset mid-transfer: reset_n=0 during the second WRITE -> M_req=0, M_wr=0, STATUS=0, interrupt=0 immediately. After release, a new START runs normally.
- Interrupt masking: INT_EN=0, run a SIZE=1 copy -> INT_FLAG reads 1, interrupt stays 0. Setting INT_EN=1 -> interrupt=1.
